// File: rtl/pc_branch_ctrl_pkg.sv
// Shared constants for the fetch-PC / branch controller: condition codes,
// flag bit positions and the controller state encoding.
package pc_branch_ctrl_pkg;

  localparam logic [2:0] COND_NE  = 3'b000;
  localparam logic [2:0] COND_EQ  = 3'b001;
  localparam logic [2:0] COND_GT  = 3'b010;
  localparam logic [2:0] COND_LT  = 3'b011;
  localparam logic [2:0] COND_GE  = 3'b100;
  localparam logic [2:0] COND_LE  = 3'b101;
  localparam logic [2:0] COND_OV  = 3'b110;
  localparam logic [2:0] COND_UNC = 3'b111;

  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_N = 0;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_SHADOW = 2'd1,
    ST_HALT   = 2'd2
  } state_t;

  // Sequential fetch step; 16-bit wrap from FFFE to 0000 is intended.
  function automatic logic [15:0] pc_step(input logic [15:0] pc);
    return pc + 16'd2;
  endfunction

endpackage

// File: rtl/pc_branch_ctrl_br_cond_eval.sv
// Pure combinational branch-condition evaluator over the effective
// {Z,V,N} flags.
module br_cond_eval
  import pc_branch_ctrl_pkg::*;
(
  input  logic [2:0] cond,
  input  logic [2:0] eff_flags,
  output logic       taken
);

  logic z;
  logic v;
  logic n;

  assign z = eff_flags[FLAG_Z];
  assign v = eff_flags[FLAG_V];
  assign n = eff_flags[FLAG_N];

  always_comb begin
    taken = 1'b0;
    case (cond)
      COND_NE:  taken = ~z;
      COND_EQ:  taken = z;
      COND_GT:  taken = ~z & ~n;
      COND_LT:  taken = n;
      COND_GE:  taken = z | (~z & ~n);
      COND_LE:  taken = n | z;
      COND_OV:  taken = v;
      COND_UNC: taken = 1'b1;
      default:  taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_branch_ctrl.sv
// Fetch PC and Z/V/N flag owner: resolves branches, redirects the PC,
// squashes the wrong-path shadow and latches HLT until reset.
module pc_branch_ctrl
  import pc_branch_ctrl_pkg::*;
#(
  parameter logic [15:0] RESET_PC      = 16'h0000,
  parameter int          SHADOW_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        br_valid,
  input  logic [2:0]  br_cond,
  input  logic [8:0]  br_imm,
  input  logic        br_is_reg,
  input  logic [15:0] br_reg,
  input  logic [15:0] br_pc_plus2,
  input  logic        halt_i,
  input  logic [2:0]  flag_wr,
  input  logic [2:0]  flag_in,
  output logic [15:0] pc_o,
  output logic [2:0]  flags_o,
  output logic        taken_o,
  output logic        flush_o,
  output logic        halted_o
);

  localparam int          SHADOW_LAST = (SHADOW_CYCLES > 0) ? SHADOW_CYCLES - 1 : 0;
  localparam logic [2:0]  SHADOW_INIT = SHADOW_LAST[2:0];

  state_t             state;
  logic [2:0]         cnt;
  logic [15:0]        pc_q;
  logic [2:0]         flags_q;
  logic               halted_q;
  logic [2:0]         eff_flags;
  logic               cond_true;
  logic               br_ok;
  logic               taken;
  logic signed [15:0] offset;
  logic [15:0]        target;

  // A flag written this cycle is already visible to the branch resolving now.
  assign eff_flags = (flag_wr & flag_in) | (~flag_wr & flags_q);

  br_cond_eval u_cond_eval (
    .cond      (br_cond),
    .eff_flags (eff_flags),
    .taken     (cond_true)
  );

  assign offset = {{6{br_imm[8]}}, br_imm, 1'b0};
  assign target = br_is_reg ? br_reg : (br_pc_plus2 + $unsigned(offset));

  // rst is gated in so nothing is reported taken while reset is held.
  assign br_ok   = br_valid & ~stall_i & (state == ST_RUN) & ~rst;
  assign taken   = br_ok & cond_true;
  assign taken_o = taken;
  assign flush_o = ~rst & (taken | (state == ST_SHADOW));

  assign pc_o     = pc_q;
  assign flags_o  = flags_q;
  assign halted_o = halted_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_q <= 3'b000;
    end else begin
      flags_q <= eff_flags;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_RUN;
      cnt      <= 3'd0;
      pc_q     <= RESET_PC;
      halted_q <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          // An older taken branch wins over a HLT decoded in the same cycle.
          if (taken) begin
            pc_q <= target;
            if (SHADOW_CYCLES > 0) begin
              state <= ST_SHADOW;
              cnt   <= SHADOW_INIT;
            end
          end else if (halt_i && !stall_i) begin
            state    <= ST_HALT;
            halted_q <= 1'b1;
          end else if (!stall_i) begin
            pc_q <= pc_step(pc_q);
          end
        end
        ST_SHADOW: begin
          if (!stall_i) begin
            pc_q <= pc_step(pc_q);
          end
          if (cnt == 3'd0) begin
            state <= ST_RUN;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        ST_HALT: begin
          halted_q <= 1'b1;
        end
        default: begin
          state <= ST_RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_branch_ctrl.sv
// Self-checking bench for pc_branch_ctrl: directed scenarios followed by
// randomized traffic, all checked against a cycle-level behavioural model.
module tb_pc_branch_ctrl;

  localparam logic [15:0] RPC    = 16'h0000;
  localparam int          SHADOW = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i;
  logic        br_valid;
  logic [2:0]  br_cond;
  logic [8:0]  br_imm;
  logic        br_is_reg;
  logic [15:0] br_reg;
  logic [15:0] br_pc_plus2;
  logic        halt_i;
  logic [2:0]  flag_wr;
  logic [2:0]  flag_in;
  logic [15:0] pc_o;
  logic [2:0]  flags_o;
  logic        taken_o;
  logic        flush_o;
  logic        halted_o;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [15:0] m_pc;
  logic [2:0]  m_flags;
  int          m_shadow;
  bit          m_halt;

  logic        last_taken;
  logic        last_flush;
  logic [15:0] saved_pc;

  pc_branch_ctrl #(.RESET_PC(RPC), .SHADOW_CYCLES(SHADOW)) dut (
    .clk         (clk),
    .rst         (rst),
    .stall_i     (stall_i),
    .br_valid    (br_valid),
    .br_cond     (br_cond),
    .br_imm      (br_imm),
    .br_is_reg   (br_is_reg),
    .br_reg      (br_reg),
    .br_pc_plus2 (br_pc_plus2),
    .halt_i      (halt_i),
    .flag_wr     (flag_wr),
    .flag_in     (flag_in),
    .pc_o        (pc_o),
    .flags_o     (flags_o),
    .taken_o     (taken_o),
    .flush_o     (flush_o),
    .halted_o    (halted_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit ref_cond(input int c, input bit z, input bit v, input bit n);
    case (c)
      0: return !z;
      1: return z;
      2: return !z && !n;
      3: return n;
      4: return z || (!z && !n);
      5: return n || z;
      6: return v;
      default: return 1'b1;
    endcase
  endfunction

  task automatic model_reset();
    m_pc     = RPC;
    m_flags  = 3'b000;
    m_shadow = 0;
    m_halt   = 1'b0;
  endtask

  task automatic idle();
    stall_i     = 1'b0;
    br_valid    = 1'b0;
    br_cond     = 3'd0;
    br_imm      = 9'd0;
    br_is_reg   = 1'b0;
    br_reg      = 16'h0000;
    br_pc_plus2 = 16'h0000;
    halt_i      = 1'b0;
    flag_wr     = 3'b000;
    flag_in     = 3'b000;
  endtask

  task automatic set_b(input logic [2:0] c, input logic [15:0] pc2, input logic [8:0] imm);
    br_valid    = 1'b1;
    br_cond     = c;
    br_is_reg   = 1'b0;
    br_pc_plus2 = pc2;
    br_imm      = imm;
  endtask

  // Called right after a negedge with inputs applied; returns at the next negedge.
  task automatic step();
    bit [2:0] eff;
    bit       ct;
    bit       run;
    bit       et;
    bit       ef;
    int       off;
    int       tgt;
    for (int i = 0; i < 3; i++) eff[i] = flag_wr[i] ? flag_in[i] : m_flags[i];
    ct  = ref_cond(int'(br_cond), eff[2], eff[1], eff[0]);
    run = !m_halt && (m_shadow == 0);
    et  = run && br_valid && !stall_i && ct;
    ef  = et || (!m_halt && m_shadow > 0);
    off = int'(br_imm);
    if (br_imm[8]) off = off - 512;
    tgt = br_is_reg ? int'(br_reg) : ((int'(br_pc_plus2) + 2 * off) & 32'hFFFF);
    #1;
    chk("pc", pc_o, m_pc);
    chk("flags", 16'(flags_o), 16'(m_flags));
    chk("taken", 16'(taken_o), 16'(et));
    chk("flush", 16'(flush_o), 16'(ef));
    chk("halted", 16'(halted_o), 16'(m_halt));
    last_taken = taken_o;
    last_flush = flush_o;
    @(posedge clk);
    m_flags = eff;
    if (m_halt) begin
      // frozen
    end else if (m_shadow > 0) begin
      if (!stall_i) m_pc = m_pc + 16'd2;
      m_shadow = m_shadow - 1;
    end else if (et) begin
      m_pc     = 16'(tgt);
      m_shadow = SHADOW;
    end else if (halt_i && !stall_i) begin
      m_halt = 1'b1;
    end else if (!stall_i) begin
      m_pc = m_pc + 16'd2;
    end
    @(negedge clk);
  endtask

  // Asserts rst between clock edges and checks its immediate effect.
  task automatic async_reset();
    #3;
    rst = 1'b1;
    #1;
    chk("arst_pc", pc_o, RPC);
    chk("arst_halted", 16'(halted_o), 16'd0);
    chk("arst_flush", 16'(flush_o), 16'd0);
    chk("arst_taken", 16'(taken_o), 16'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    model_reset();
    // Drive a live branch during reset: it must not be reported.
    set_b(3'd7, 16'h0100, 9'd0);
    #1;
    chk("rst_pc", pc_o, RPC);
    chk("rst_flags", 16'(flags_o), 16'd0);
    chk("rst_taken", 16'(taken_o), 16'd0);
    chk("rst_flush", 16'(flush_o), 16'd0);
    repeat (2) @(negedge clk);
    chk("rst_pc_held", pc_o, RPC);
    rst = 1'b0;
    idle();

    // Reset then run
    step();
    chk("run_pc2", pc_o, 16'h0002);
    step();
    chk("run_pc4", pc_o, 16'h0004);

    // Taken B-EQ plus ignored shadow branch
    flag_wr = 3'b100; flag_in = 3'b100;
    step();
    idle();
    set_b(3'b001, 16'h0010, 9'h1FE);
    step();
    chk("beq_taken", 16'(last_taken), 16'd1);
    chk("beq_flush", 16'(last_flush), 16'd1);
    chk("beq_target", pc_o, 16'h000C);
    set_b(3'b111, 16'h0100, 9'd0);
    step();
    chk("shadow_taken", 16'(last_taken), 16'd0);
    chk("shadow_flush", 16'(last_flush), 16'd1);
    chk("shadow_pc", pc_o, 16'h000E);
    idle();
    step();
    chk("post_shadow_flush", 16'(last_flush), 16'd0);

    // Flag bypass and LE
    flag_wr = 3'b111; flag_in = 3'b000;
    step();
    idle();
    flag_wr = 3'b100; flag_in = 3'b100;
    set_b(3'b101, 16'h0040, 9'd0);
    step();
    chk("le_bypass", 16'(last_taken), 16'd1);
    idle();
    step();
    flag_wr = 3'b111; flag_in = 3'b000;
    step();
    idle();
    set_b(3'b101, 16'h0040, 9'd0);
    step();
    chk("le_no_bypass", 16'(last_taken), 16'd0);
    idle();
    flag_wr = 3'b111; flag_in = 3'b100;
    step();
    idle();
    set_b(3'b101, 16'h0060, 9'd0);
    step();
    chk("le_z", 16'(last_taken), 16'd1);
    idle();
    step();

    // Wrap and BR
    set_b(3'b111, 16'hFFFE, 9'd2);
    step();
    chk("wrap_pc", pc_o, 16'h0002);
    idle();
    step();
    br_valid = 1'b1; br_cond = 3'b111; br_is_reg = 1'b1; br_reg = 16'h1234;
    step();
    chk("br_pc", pc_o, 16'h1234);
    idle();
    step();

    // Halt and priority
    set_b(3'b111, 16'h0200, 9'd0);
    halt_i = 1'b1;
    step();
    chk("halt_prio_halted", 16'(halted_o), 16'd0);
    chk("halt_prio_pc", pc_o, 16'h0200);
    idle();
    step();
    halt_i = 1'b1;
    step();
    chk("halt_set", 16'(halted_o), 16'd1);
    saved_pc = pc_o;
    for (int i = 0; i < 12; i++) begin
      stall_i  = 1'($urandom_range(0, 1));
      br_valid = 1'b1;
      br_cond  = 3'b111;
      halt_i   = 1'($urandom_range(0, 1));
      flag_wr  = 3'($urandom);
      flag_in  = 3'($urandom);
      step();
    end
    chk("halt_frozen", pc_o, saved_pc);
    chk("halt_flags", 16'(flags_o), 16'(m_flags));
    idle();
    async_reset();

    // Stall
    step();
    saved_pc = pc_o;
    stall_i = 1'b1;
    set_b(3'b111, 16'h0300, 9'd0);
    step();
    chk("stall_taken", 16'(last_taken), 16'd0);
    step();
    step();
    chk("stall_pc", pc_o, saved_pc);
    idle();
    step();

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      stall_i     = ($urandom_range(0, 3) == 0);
      br_valid    = ($urandom_range(0, 2) == 0);
      br_cond     = 3'($urandom);
      br_imm      = 9'($urandom);
      br_is_reg   = ($urandom_range(0, 3) == 0);
      br_reg      = 16'($urandom);
      br_pc_plus2 = 16'($urandom);
      halt_i      = ($urandom_range(0, 39) == 0);
      flag_wr     = 3'($urandom);
      flag_in     = 3'($urandom);
      step();
      if ((m_halt && $urandom_range(0, 5) == 0) || $urandom_range(0, 149) == 0) begin
        idle();
        async_reset();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
